// File: rtl/vga_timing_pkg.sv
// Shared constants, region encoding and timing helpers for the VGA timing generator.
// Defaults describe 640x480@60 with an 8-pixel border around the active area.
package vga_timing_pkg;

  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 40;
  localparam int unsigned DEF_H_LEFT   = 8;
  localparam int unsigned DEF_H_VALID  = 640;
  localparam int unsigned DEF_H_RIGHT  = 8;
  localparam int unsigned DEF_H_FRONT  = 8;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 25;
  localparam int unsigned DEF_V_TOP    = 8;
  localparam int unsigned DEF_V_VALID  = 480;
  localparam int unsigned DEF_V_BOTTOM = 8;
  localparam int unsigned DEF_V_FRONT  = 2;

  typedef enum logic [1:0] {SYNC, PORCH, BORDER, ACTIVE} region_t;

  function automatic int unsigned total6(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d,
                                         input int unsigned e, input int unsigned f);
    return a + b + c + d + e + f;
  endfunction

  function automatic int unsigned act_start(input int unsigned sync, input int unsigned back,
                                            input int unsigned border);
    return sync + back + border;
  endfunction

  // Classify one axis position; the border band wraps the active span on both sides.
  function automatic region_t region_of(input int unsigned cnt,   input int unsigned sync,
                                        input int unsigned back,  input int unsigned lead_b,
                                        input int unsigned valid, input int unsigned trail_b);
    int unsigned act;
    act = sync + back + lead_b;
    if (cnt < sync)                         return SYNC;
    else if (cnt < act - lead_b)            return PORCH;
    else if (cnt < act)                     return BORDER;
    else if (cnt < act + valid)             return ACTIVE;
    else if (cnt < act + valid + trail_b)   return BORDER;
    else                                    return PORCH;
  endfunction

endpackage

// File: rtl/vga_cnt.sv
// Wrap counter 0..MAX with enable and synchronous clear; o_wrap flags the enabled
// terminal count so it can chain into the next counter's enable.
module vga_cnt #(
  parameter int unsigned MAX = 799,
  parameter int unsigned W   = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == MAX_C);
  assign o_wrap   = i_en && w_at_max;
  assign o_cnt    = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (i_en)    r_cnt <= w_at_max ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with border colour, configurable pixel-request
// lead for pipelined sources, and frame/line strobes. All outputs are registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned        H_SYNC       = DEF_H_SYNC,
  parameter int unsigned        H_BACK       = DEF_H_BACK,
  parameter int unsigned        H_LEFT       = DEF_H_LEFT,
  parameter int unsigned        H_VALID      = DEF_H_VALID,
  parameter int unsigned        H_RIGHT      = DEF_H_RIGHT,
  parameter int unsigned        H_FRONT      = DEF_H_FRONT,
  parameter int unsigned        V_SYNC       = DEF_V_SYNC,
  parameter int unsigned        V_BACK       = DEF_V_BACK,
  parameter int unsigned        V_TOP        = DEF_V_TOP,
  parameter int unsigned        V_VALID      = DEF_V_VALID,
  parameter int unsigned        V_BOTTOM     = DEF_V_BOTTOM,
  parameter int unsigned        V_FRONT      = DEF_V_FRONT,
  parameter logic               SYNC_POL     = 1'b1,
  parameter int unsigned        REQ_LEAD     = 1,
  parameter int unsigned        DATA_W       = 16,
  parameter int unsigned        CNT_W        = 11,
  parameter logic [DATA_W-1:0]  BORDER_COLOR = '0
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic [DATA_W-1:0] vga_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic              line_start
);
  localparam int unsigned H_TOTAL   = total6(H_SYNC, H_BACK, H_LEFT, H_VALID, H_RIGHT, H_FRONT);
  localparam int unsigned V_TOTAL   = total6(V_SYNC, V_BACK, V_TOP, V_VALID, V_BOTTOM, V_FRONT);
  localparam int unsigned H_ACT     = act_start(H_SYNC, H_BACK, H_LEFT);
  localparam int unsigned V_ACT     = act_start(V_SYNC, V_BACK, V_TOP);
  localparam int unsigned REQ_START = H_ACT - REQ_LEAD;
  localparam int unsigned REQ_END   = H_ACT + H_VALID - REQ_LEAD;

  localparam logic [CNT_W-1:0] REQ_START_C = CNT_W'(REQ_START);
  localparam logic [CNT_W-1:0] V_ACT_C     = CNT_W'(V_ACT);

  logic [CNT_W-1:0] w_cnt_h, w_cnt_v;
  logic [CNT_W-1:0] w_h, w_v;
  logic [31:0]      w_h32, w_v32;
  logic             w_h_wrap, w_v_wrap_unused;
  region_t          w_h_region, w_v_region;
  logic             w_active, w_border, w_req;

  vga_cnt #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_cnt_h (
    .i_clk   (vga_clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_clr   (~en),
    .o_cnt   (w_cnt_h),
    .o_wrap  (w_h_wrap)
  );

  vga_cnt #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_cnt_v (
    .i_clk   (vga_clk),
    .i_rst_n (rst_n),
    .i_en    (w_h_wrap),
    .i_clr   (~en),
    .o_cnt   (w_cnt_v),
    .o_wrap  (w_v_wrap_unused)
  );

  // While disabled the decode sees (0,0), so outputs settle to the frame-origin state.
  assign w_h   = en ? w_cnt_h : '0;
  assign w_v   = en ? w_cnt_v : '0;
  assign w_h32 = 32'(w_h);
  assign w_v32 = 32'(w_v);

  assign w_h_region = region_of(w_h32, H_SYNC, H_BACK, H_LEFT, H_VALID, H_RIGHT);
  assign w_v_region = region_of(w_v32, V_SYNC, V_BACK, V_TOP, V_VALID, V_BOTTOM);

  assign w_active = (w_h_region == ACTIVE) && (w_v_region == ACTIVE);
  assign w_border = (w_h_region inside {BORDER, ACTIVE}) &&
                    (w_v_region inside {BORDER, ACTIVE}) && !w_active;
  assign w_req    = (w_v_region == ACTIVE) && (w_h32 >= REQ_START) && (w_h32 < REQ_END);

  logic              r_pix_req, r_hsync, r_vsync, r_de, r_frame_start, r_line_start;
  logic [CNT_W-1:0]  r_pix_x, r_pix_y;
  logic [DATA_W-1:0] r_vga_rgb;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_pix_req     <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_vga_rgb     <= '0;
      r_pix_x       <= '1;
      r_pix_y       <= '1;
    end else begin
      r_hsync       <= (w_h_region == SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_v_region == SYNC) ? SYNC_POL : ~SYNC_POL;
      r_de          <= w_active;
      r_pix_req     <= w_req;
      r_frame_start <= en && (w_h == '0) && (w_v == '0);
      r_line_start  <= en && (w_h == '0);
      r_vga_rgb     <= w_active ? pix_data : (w_border ? BORDER_COLOR : '0);
      r_pix_x       <= w_req ? (w_h - REQ_START_C) : '1;
      r_pix_y       <= w_req ? (w_v - V_ACT_C) : '1;
    end
  end

  assign pix_req     = r_pix_req;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign vga_rgb     = r_vga_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule
